msp430_timer16: RTL and testbench
=================================

MSP430_TIMER16 -- requirements
Module: msp430_timer16

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 15'h01A0: byte base address, aligned to 32 bytes.
REQ-002 SHALL have parameter NUM_CH, default 2: number of timer channels, legal range 1..4.
REQ-003 SHALL have port mclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port puc_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port per_addr, input, 14 bits: peripheral word address.
REQ-006 SHALL have port per_din, input, 16 bits: peripheral write data.
REQ-007 SHALL have port per_en, input, 1 bit: peripheral access enable, active high.
REQ-008 SHALL have port per_we, input, 2 bits: byte write enables; [0] low byte, [1] high byte.
REQ-009 SHALL have port per_dout, output, 16 bits: read data; zero when not read.
REQ-010 SHALL have port irq, output, NUM_CH bits: per-channel interrupt request, active high.

Function
REQ-011 SHALL select the block when per_en=1 and per_addr[13:4] equals BASE_ADDR[14:5]; local byte offset = {per_addr[3:0],1'b0}.
REQ-012 SHALL place channel c at offset 8*c, with registers CTL +0, CNT +2, CMP +4, STAT +6.
REQ-013 SHALL treat per_we!=0 as a write and per_we==0 as a read; reads are combinational in the same cycle.
REQ-014 SHALL return 0 on per_dout for unselected accesses, channels >= NUM_CH, and unimplemented bits.
REQ-015 SHALL apply byte writes per lane: per_we[0] updates bits [7:0], per_we[1] updates bits [15:8], and both lanes update all 16 bits.
REQ-016 SHALL define CTL bits: [0] EN, [1] MODE (0 one-shot, 1 periodic), [2] IE, [5:4] DIV (see REQ-026); all other CTL bits read 0.
REQ-017 SHALL define STAT bit [0] as IFG: writing 1 clears it, writing 0 has no effect.
REQ-018 SHALL, on every tick with EN=1, either increment CNT by 1 or, when CNT==CMP, set IFG and load CNT with 0 on the same edge.
REQ-019 SHALL, on a compare match in one-shot mode, also clear EN on the same edge.
REQ-020 SHALL wrap CNT from 16'hFFFF to 0 without setting IFG when CMP is never matched.
REQ-021 SHALL give a CNT bus write priority over increment and compare reload in the same cycle.
REQ-022 SHALL give a hardware IFG set priority over a simultaneous write-1-to-clear.
REQ-023 SHALL give a CTL bus write of EN priority over the one-shot auto-clear in the same cycle.
REQ-024 SHALL drive irq[c] = IFG[c] & IE[c] combinationally.

Reset
REQ-025 SHALL, while puc_rst=1 and asynchronously, clear all CTL, CNT, CMP, IFG and prescaler state to 0, forcing irq=0 and per_dout=0; after release, counting begins only once EN is written.

Configuration
REQ-026 SHALL, when MSP430_TIMER16_PRESCALER_EN is defined, include a free-running 3-bit prescaler and produce a channel tick when the prescaler's low DIV bits are zero (divide by 1/2/4/8); DIV is read/write.
REQ-027 SHALL, when MSP430_TIMER16_PRESCALER_EN is undefined, tick every cycle, read DIV as 0, and ignore writes to DIV.

Verification
REQ-028 SHALL be verified by: CMP=3, CTL=16'h0007 (EN, periodic, IE) -> IFG and irq rise after 4 ticks; CNT sequence 0,1,2,3,0,1...; IFG re-sets every 4 ticks.
REQ-029 SHALL be verified by: CMP=2, CTL=16'h0005 (one-shot) -> one IFG set, EN reads 0 afterwards, CNT holds 0.
REQ-030 SHALL be verified by: per_we=2'b10 with per_din=16'hAB12 to CMP=16'h0034 -> CMP reads 16'hAB34.
REQ-031 SHALL be verified by: write STAT=1 on the same edge as a compare match -> IFG stays 1; a second write STAT=1 -> IFG=0 and irq=0.
REQ-032 SHALL be verified by: write CNT=16'h0010 during a running count -> CNT reads 16'h0010 next cycle; with the macro on and DIV=2, CNT steps every 4 cycles.
REQ-033 SHALL be verified by: assert puc_rst mid-count with IFG=1 -> all registers read 0 and irq=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/msp430_timer16.sv
// MSP430 peripheral-bus timer: NUM_CH compare channels with CTL/CNT/CMP/STAT registers.
// Define MSP430_TIMER16_PRESCALER_EN to add a shared 3-bit prescaler and a per-channel DIV field.
module msp430_timer16 #(
    parameter logic [14:0] BASE_ADDR = 15'h01A0,
    parameter int unsigned NUM_CH    = 2
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic [13:0]       per_addr,
    input  logic [15:0]       per_din,
    input  logic              per_en,
    input  logic [1:0]        per_we,
    output logic [15:0]       per_dout,
    output logic [NUM_CH-1:0] irq
);

    typedef enum logic [1:0] {
        RegCtl  = 2'd0,
        RegCnt  = 2'd1,
        RegCmp  = 2'd2,
        RegStat = 2'd3
    } reg_e;

    logic       sel;
    logic       wr;
    logic       rd;
    logic [1:0] acc_ch;
    reg_e       acc_reg;

    // Word address: [13:4] block select, [3:2] channel, [1:0] register.
    assign sel     = per_en & (per_addr[13:4] == BASE_ADDR[14:5]);
    assign wr      = sel & (per_we != 2'b00);
    assign rd      = sel & (per_we == 2'b00);
    assign acc_ch  = per_addr[3:2];
    assign acc_reg = reg_e'(per_addr[1:0]);

    function automatic logic [15:0] lane_merge(input logic [15:0] old_val,
                                               input logic [15:0] din,
                                               input logic [1:0]  we);
        logic [15:0] res;
        res = old_val;
        if (we[0]) res[7:0] = din[7:0];
        if (we[1]) res[15:8] = din[15:8];
        return res;
    endfunction

    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] ie_q, ie_d;
    logic [NUM_CH-1:0] ifg_q, ifg_d;
    logic [15:0]       cnt_q [NUM_CH];
    logic [15:0]       cnt_d [NUM_CH];
    logic [15:0]       cmp_q [NUM_CH];
    logic [15:0]       cmp_d [NUM_CH];

    logic [NUM_CH-1:0] wr_ctl;
    logic [NUM_CH-1:0] wr_cnt;
    logic [NUM_CH-1:0] wr_cmp;
    logic [NUM_CH-1:0] wr_stat;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] match;
    logic [1:0]        div [NUM_CH];

    always_comb begin
        wr_ctl  = '0;
        wr_cnt  = '0;
        wr_cmp  = '0;
        wr_stat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr && (acc_ch == 2'(c))) begin
                wr_ctl[c]  = (acc_reg == RegCtl);
                wr_cnt[c]  = (acc_reg == RegCnt);
                wr_cmp[c]  = (acc_reg == RegCmp);
                wr_stat[c] = (acc_reg == RegStat);
            end
        end
    end

`ifdef MSP430_TIMER16_PRESCALER_EN
    logic [2:0] presc_q;
    logic [1:0] div_q [NUM_CH];

    function automatic logic [2:0] div_mask(input logic [1:0] d);
        logic [2:0] m;
        unique case (d)
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            presc_q <= 3'd0;
            for (int c = 0; c < NUM_CH; c++) begin
                div_q[c] <= 2'd0;
            end
        end else begin
            presc_q <= presc_q + 3'd1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_ctl[c] && per_we[0]) div_q[c] <= per_din[5:4];
            end
        end
    end

    // A channel ticks when the prescaler's low DIV bits are all zero.
    always_comb begin
        tick = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            div[c]  = div_q[c];
            tick[c] = ((presc_q & div_mask(div_q[c])) == 3'b000);
        end
    end
`else
    always_comb begin
        tick = '1;
        for (int c = 0; c < NUM_CH; c++) begin
            div[c] = 2'd0;
        end
    end
`endif

    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        ie_d   = ie_q;
        ifg_d  = ifg_q;
        match  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            match[c] = en_q[c] & tick[c] & (cnt_q[c] == cmp_q[c]);

            // Bus write to CNT overrides both increment and compare reload.
            cnt_d[c] = cnt_q[c];
            if (wr_cnt[c]) begin
                cnt_d[c] = lane_merge(cnt_q[c], per_din, per_we);
            end else if (match[c]) begin
                cnt_d[c] = 16'h0000;
            end else if (en_q[c] && tick[c]) begin
                cnt_d[c] = cnt_q[c] + 16'd1;
            end

            cmp_d[c] = wr_cmp[c] ? lane_merge(cmp_q[c], per_din, per_we) : cmp_q[c];

            // Hardware set wins over write-1-to-clear.
            if (match[c]) begin
                ifg_d[c] = 1'b1;
            end else if (wr_stat[c] && per_we[0] && per_din[0]) begin
                ifg_d[c] = 1'b0;
            end

            if (match[c] && !mode_q[c]) en_d[c] = 1'b0;
            if (wr_ctl[c] && per_we[0]) begin
                en_d[c]   = per_din[0];
                mode_d[c] = per_din[1];
                ie_d[c]   = per_din[2];
            end
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            en_q   <= '0;
            mode_q <= '0;
            ie_q   <= '0;
            ifg_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= 16'h0000;
                cmp_q[c] <= 16'h0000;
            end
        end else begin
            en_q   <= en_d;
            mode_q <= mode_d;
            ie_q   <= ie_d;
            ifg_q  <= ifg_d;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
                cmp_q[c] <= cmp_d[c];
            end
        end
    end

    always_comb begin
        per_dout = 16'h0000;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd && (acc_ch == 2'(c))) begin
                unique case (acc_reg)
                    RegCtl:  per_dout = {10'h000, div[c], 1'b0, ie_q[c], mode_q[c], en_q[c]};
                    RegCnt:  per_dout = cnt_q[c];
                    RegCmp:  per_dout = cmp_q[c];
                    default: per_dout = {15'h0000, ifg_q[c]};
                endcase
            end
        end
    end

    assign irq = ifg_q & ie_q;

endmodule

// File: tb/tb_msp430_timer16.sv
// Self-checking bench for msp430_timer16: directed scenarios plus random bus traffic vs a model.
`timescale 1ns/1ps
module tb_msp430_timer16;

    localparam logic [14:0] BASE_ADDR = 15'h01A0;
    localparam int          NUM_CH    = 2;

    logic              mclk = 1'b0;
    logic              puc_rst;
    logic [13:0]       per_addr;
    logic [15:0]       per_din;
    logic              per_en;
    logic [1:0]        per_we;
    logic [15:0]       per_dout;
    logic [NUM_CH-1:0] irq;

    int checks = 0;
    int errors = 0;

    msp430_timer16 #(
        .BASE_ADDR(BASE_ADDR),
        .NUM_CH   (NUM_CH)
    ) dut (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .per_addr(per_addr),
        .per_din (per_din),
        .per_en  (per_en),
        .per_we  (per_we),
        .per_dout(per_dout),
        .irq     (irq)
    );

    always #50 mclk = ~mclk;

    // Reference model: register contents per channel plus a cycle count for the prescaler.
    logic        m_en   [4];
    logic        m_mode [4];
    logic        m_ie   [4];
    logic        m_ifg  [4];
    logic [1:0]  m_div  [4];
    logic [15:0] m_cnt  [4];
    logic [15:0] m_cmp  [4];
    int          m_cyc;

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_en[c] = 0; m_mode[c] = 0; m_ie[c] = 0; m_ifg[c] = 0;
            m_div[c] = 2'd0; m_cnt[c] = 16'h0; m_cmp[c] = 16'h0;
        end
        m_cyc = 0;
    endtask

    function automatic logic [15:0] m_read(input int ch, input int r);
        if (ch >= NUM_CH) return 16'h0000;
        case (r)
            0:       return {10'h000, m_div[ch], 1'b0, m_ie[ch], m_mode[ch], m_en[ch]};
            1:       return m_cnt[ch];
            2:       return m_cmp[ch];
            default: return {15'h0000, m_ifg[ch]};
        endcase
    endfunction

    function automatic logic [15:0] m_irq();
        logic [15:0] v;
        v = 16'h0000;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_ifg[c] & m_ie[c];
        return v;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d,
                                          input logic [1:0] we);
        logic [15:0] r;
        r = o;
        if (we[0]) r[7:0] = d[7:0];
        if (we[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    task automatic model_step(input logic en, input logic [13:0] addr, input logic [1:0] we,
                              input logic [15:0] din);
        logic        sel, run, hit, n_en, n_ifg;
        logic [15:0] n_cnt;
        int          ch, r, period;
        sel = en && (addr[13:4] == BASE_ADDR[14:5]) && (we != 2'b00);
        ch  = int'(addr[3:2]);
        r   = int'(addr[1:0]);
        for (int c = 0; c < NUM_CH; c++) begin
            period = 1 << m_div[c];
            run    = m_en[c] && ((m_cyc % period) == 0);
            hit    = run && (m_cnt[c] == m_cmp[c]);
            n_cnt  = hit ? 16'h0000 : (run ? m_cnt[c] + 16'd1 : m_cnt[c]);
            n_ifg  = hit ? 1'b1 : m_ifg[c];
            n_en   = (hit && !m_mode[c]) ? 1'b0 : m_en[c];
            if (sel && ch == c) begin
                if (r == 0 && we[0]) begin
                    n_en      = din[0];
                    m_mode[c] = din[1];
                    m_ie[c]   = din[2];
`ifdef MSP430_TIMER16_PRESCALER_EN
                    m_div[c]  = din[5:4];
`endif
                end
                if (r == 1) n_cnt = merge(m_cnt[c], din, we);
                if (r == 2) m_cmp[c] = merge(m_cmp[c], din, we);
                if (r == 3 && we[0] && din[0] && !hit) n_ifg = 1'b0;
            end
            m_cnt[c] = n_cnt;
            m_ifg[c] = n_ifg;
            m_en[c]  = n_en;
        end
        m_cyc++;
    endtask

    function automatic logic [13:0] a(input int ch, input int r);
        return {BASE_ADDR[14:5], 2'(ch), 2'(r)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, check per_dout before the edge, clock, step the model.
    task automatic do_cycle(input logic en, input logic [13:0] addr, input logic [1:0] we,
                            input logic [15:0] din);
        logic [15:0] exp;
        per_en = en; per_addr = addr; per_we = we; per_din = din;
        exp = (en && addr[13:4] == BASE_ADDR[14:5] && we == 2'b00)
              ? m_read(int'(addr[3:2]), int'(addr[1:0])) : 16'h0000;
        #1;
        chk("dout", per_dout, exp);
        @(posedge mclk);
        model_step(en, addr, we, din);
        @(negedge mclk);
        per_en = 1'b0; per_we = 2'b00;
    endtask

    task automatic wr(input int ch, input int r, input logic [1:0] we, input logic [15:0] din);
        do_cycle(1'b1, a(ch, r), we, din);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 14'h0, 2'b00, 16'h0);
    endtask

    task automatic rd(input int ch, input int r, output logic [15:0] v);
        per_en = 1'b1; per_addr = a(ch, r); per_we = 2'b00;
        #1;
        v = per_dout;
        per_en = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        logic [15:0] v;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd(c, r, v);
                chk($sformatf("%s ch%0d r%0d", tag, c, r), v, m_read(c, r));
            end
        end
        chk({tag, " irq"}, 16'(irq), m_irq());
    endtask

    initial begin
        logic [15:0] v, c0, c1;
        per_en = 1'b0; per_addr = 14'h0; per_we = 2'b00; per_din = 16'h0;
        puc_rst = 1'b1;
        model_reset();
        #1;
        chk_model("reset");
        @(negedge mclk);
        puc_rst = 1'b0;

        // No counting until EN is written.
        idle(3);
        rd(0, 1, v); chk("idle cnt", v, 16'h0000);
        chk_model("idle");

        // Periodic: CMP=3, CTL=EN|MODE|IE; IFG cleared once mid-run.
        wr(0, 2, 2'b11, 16'h0003);
        wr(0, 0, 2'b11, 16'h0007);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) wr(0, 3, 2'b11, 16'h0001);
            else idle(1);
            rd(0, 1, v);
            chk($sformatf("per cnt %0d", i), v, (i % 4 == 3) ? 16'h0 : 16'(i % 4 + 1));
            chk($sformatf("per irq %0d", i), 16'(irq[0]), (i % 4 == 3) ? 16'h1 : 16'h0);
        end
        chk_model("periodic");

        // Byte lanes and unimplemented bits.
        wr(0, 0, 2'b11, 16'h0000);
        wr(0, 2, 2'b11, 16'h0034);
        wr(0, 2, 2'b10, 16'hAB12);
        rd(0, 2, v); chk("cmp hi lane", v, 16'hAB34);
        wr(0, 2, 2'b01, 16'h5678);
        rd(0, 2, v); chk("cmp lo lane", v, 16'hAB78);
        wr(0, 0, 2'b10, 16'hFFFF);
        rd(0, 0, v); chk("ctl hi only", v, 16'h0000);
        wr(0, 0, 2'b11, 16'hFFFF);
        rd(0, 0, v);
`ifdef MSP430_TIMER16_PRESCALER_EN
        chk("ctl mask", v, 16'h0037);
`else
        chk("ctl mask", v, 16'h0007);
`endif
        wr(0, 0, 2'b11, 16'h0000);
        wr(2, 2, 2'b11, 16'h1234);
        rd(2, 2, v); chk("ch2 absent", v, 16'h0000);
        per_addr = a(0, 2); per_en = 1'b0; #1;
        chk("unselected", per_dout, 16'h0000);
        chk_model("lanes");

        // One-shot on ch1.
        wr(1, 0, 2'b11, 16'h0000); wr(1, 3, 2'b11, 16'h0001);
        wr(1, 1, 2'b11, 16'h0000); wr(1, 2, 2'b11, 16'h0002);
        wr(1, 0, 2'b11, 16'h0005);
        idle(5);
        rd(1, 0, v); chk("os ctl", v, 16'h0004);
        rd(1, 1, v); chk("os cnt", v, 16'h0000);
        rd(1, 3, v); chk("os ifg", v, 16'h0001);
        chk("os irq", 16'(irq[1]), 16'h0001);

        // CTL EN write beats one-shot auto-clear.
        wr(1, 3, 2'b11, 16'h0001);
        wr(1, 0, 2'b11, 16'h0005);
        idle(2);
        wr(1, 0, 2'b11, 16'h0005);
        rd(1, 0, v); chk("en prio ctl", v, 16'h0005);
        rd(1, 3, v); chk("en prio ifg", v, 16'h0001);
        idle(1);
        rd(1, 1, v); chk("en prio cnt", v, 16'h0001);
        chk_model("oneshot");

        // Hardware IFG set beats write-1-to-clear.
        wr(0, 0, 2'b11, 16'h0000); wr(0, 3, 2'b11, 16'h0001);
        wr(0, 1, 2'b11, 16'h0000); wr(0, 2, 2'b11, 16'h0003);
        wr(0, 0, 2'b11, 16'h0007);
        idle(3);
        wr(0, 3, 2'b11, 16'h0001);
        rd(0, 3, v); chk("w1c race ifg", v, 16'h0001);
        chk("w1c race irq", 16'(irq[0]), 16'h0001);
        wr(0, 0, 2'b11, 16'h0000);
        wr(0, 3, 2'b11, 16'h0001);
        rd(0, 3, v); chk("w1c ifg", v, 16'h0000);
        chk("w1c irq", 16'(irq[0]), 16'h0000);

        // Wrap FFFF -> 0 without IFG.
        wr(1, 0, 2'b11, 16'h0000); wr(1, 3, 2'b11, 16'h0001);
        wr(1, 2, 2'b11, 16'h0005); wr(1, 1, 2'b11, 16'hFFFE);
        wr(1, 0, 2'b11, 16'h0007);
        idle(1); rd(1, 1, v); chk("wrap ffff", v, 16'hFFFF);
        idle(1); rd(1, 1, v); chk("wrap zero", v, 16'h0000);
        rd(1, 3, v); chk("wrap ifg", v, 16'h0000);
        chk_model("wrap");

        // CNT write while running.
        wr(0, 2, 2'b11, 16'h0100); wr(0, 1, 2'b11, 16'h0000);
        wr(0, 0, 2'b11, 16'h0007);
        idle(3);
        wr(0, 1, 2'b11, 16'h0010);
        rd(0, 1, v); chk("cnt wr", v, 16'h0010);
        idle(1);
        rd(0, 1, v); chk("cnt wr next", v, 16'h0011);
`ifdef MSP430_TIMER16_PRESCALER_EN
        wr(0, 1, 2'b11, 16'h0000);
        wr(0, 0, 2'b11, 16'h0023);
        rd(0, 1, c0);
        idle(12);
        rd(0, 1, c1);
        chk("div4 steps", c1 - c0, 16'd3);
`endif
        chk_model("cntwr");

        // Asynchronous reset mid-count with IFG pending.
        wr(0, 0, 2'b11, 16'h0000); wr(0, 3, 2'b11, 16'h0001);
        wr(0, 1, 2'b11, 16'h0000); wr(0, 2, 2'b11, 16'h0001);
        wr(0, 0, 2'b11, 16'h0007);
        idle(2);
        chk("pre rst irq", 16'(irq[0]), 16'h0001);
        puc_rst = 1'b1;
        model_reset();
        #1;
        chk("async irq", 16'(irq), 16'h0000);
        chk_model("async rst");
        @(negedge mclk);
        puc_rst = 1'b0;
        idle(2);
        rd(0, 1, v); chk("post rst cnt", v, 16'h0000);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int          kind, ch, r;
            logic [1:0]  we;
            logic [15:0] din;
            logic [13:0] ad;
            kind = $urandom_range(0, 9);
            ch   = $urandom_range(0, 3);
            r    = $urandom_range(0, 3);
            we   = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(1, 3));
            din  = 16'($urandom);
            if ((r == 1 || r == 2) && $urandom_range(0, 7) != 0) din = 16'($urandom_range(0, 9));
            if (kind == 0) begin
                do_cycle(1'b0, a(ch, r), we, din);
            end else if (kind == 1) begin
                ad = 14'($urandom);
                if (ad[13:4] == BASE_ADDR[14:5]) ad[13] = ~ad[13];
                do_cycle(1'b1, ad, we, din);
            end else begin
                do_cycle(1'b1, a(ch, r), we, din);
            end
            chk("rand irq", 16'(irq), m_irq());
            if (i % 25 == 24) chk_model("rand");
        end
        chk_model("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
